mod_adder_pipe: RTL and testbench

Pipelined modular adder computing (a + b) mod P over LEVEL register stages, with a valid/ready handshake and a sideband control word carried alongside each operand pair. It is the addition counterpart to the team's pipelined modular subtractor and sits in the same finite-field datapaths (point add/double, multiplier reduction trees). It accepts one operation per cycle and tolerates downstream backpressure without losing or duplicating data.

---
 rtl/mod_adder_pipe.sv | 126 ++++++++++++
 tb/tb_mod_adder_pipe.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_adder_pipe.sv
// Pipelined modular adder: (a + b) mod P split into LEVEL slice stages, each carrying a sum and
// a (sum - P) chain, with valid/ready flow control and a sideband control word.
module mod_adder_pipe #(
  parameter int unsigned P        = 251,
  parameter int unsigned BITS     = $clog2(P),
  parameter int unsigned CTL_BITS = 8,
  parameter int unsigned LEVEL    = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [BITS-1:0]     i_dat_a,
  input  logic [BITS-1:0]     i_dat_b,
  input  logic                i_val,
  input  logic [CTL_BITS-1:0] i_ctl,
  output logic                o_rdy,
  output logic                o_val,
  output logic [BITS-1:0]     o_dat,
  output logic [CTL_BITS-1:0] o_ctl,
  input  logic                i_rdy
);

  localparam int unsigned SLICE    = (BITS + LEVEL - 1) / LEVEL;
  localparam int unsigned DAT_BITS = LEVEL * SLICE;
  localparam logic [DAT_BITS-1:0] P_EXT = DAT_BITS'(P);

  // Stage registers; index g holds the result of slice stage g.
  logic [LEVEL-1:0][DAT_BITS-1:0] a_q, b_q, sum_q, dif_q;
  logic [LEVEL-1:0][CTL_BITS-1:0] ctl_q;
  logic [LEVEL-1:0]               val_q, cry_q, brw_q;

  // Next-state values computed by each slice stage.
  logic [LEVEL-1:0][DAT_BITS-1:0] sum_d, dif_d;
  logic [LEVEL-1:0]               cry_d, brw_d;
  logic [LEVEL-1:0]               rdy;

  // Stage inputs: element 0 is the block input, element g is register g-1, element LEVEL is
  // the final register feeding the output select.
  logic [LEVEL:0][DAT_BITS-1:0] a_in, b_in, sum_in, dif_in;
  logic [LEVEL:0][CTL_BITS-1:0] ctl_in;
  logic [LEVEL:0]               val_in, cry_in, brw_in;

  assign a_in   = {a_q, DAT_BITS'(i_dat_a)};
  assign b_in   = {b_q, DAT_BITS'(i_dat_b)};
  assign sum_in = {sum_q, {DAT_BITS{1'b0}}};
  assign dif_in = {dif_q, {DAT_BITS{1'b0}}};
  assign ctl_in = {ctl_q, i_ctl};
  assign val_in = {val_q, i_val};
  assign cry_in = {cry_q, 1'b0};
  assign brw_in = {brw_q, 1'b0};

  logic [SLICE:0] sl_sum, sl_dif;

  always_comb begin
    sum_d  = '0;
    dif_d  = '0;
    cry_d  = '0;
    brw_d  = '0;
    sl_sum = '0;
    sl_dif = '0;
    for (int g = 0; g < LEVEL; g++) begin
      sl_sum = {1'b0, a_in[g][g*SLICE +: SLICE]} + {1'b0, b_in[g][g*SLICE +: SLICE]}
             + (SLICE+1)'(cry_in[g]);
      // Subtract P from the freshly formed sum slice; the borrow ripples to the next stage.
      sl_dif = {1'b0, sl_sum[SLICE-1:0]} - {1'b0, P_EXT[g*SLICE +: SLICE]}
             - (SLICE+1)'(brw_in[g]);
      sum_d[g]                    = sum_in[g];
      sum_d[g][g*SLICE +: SLICE]  = sl_sum[SLICE-1:0];
      dif_d[g]                    = dif_in[g];
      dif_d[g][g*SLICE +: SLICE]  = sl_dif[SLICE-1:0];
      cry_d[g]                    = sl_sum[SLICE];
      brw_d[g]                    = sl_dif[SLICE];
    end
  end

  // A stage may load when any stage at or after it holds a bubble, or the output drains.
  always_comb begin
    rdy = '0;
    for (int g = 0; g < LEVEL; g++) begin
      rdy[g] = i_rdy;
      for (int k = g; k < LEVEL; k++) begin
        if (!val_q[k]) rdy[g] = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      dif_q <= '0;
      ctl_q <= '0;
      val_q <= '0;
      cry_q <= '0;
      brw_q <= '0;
    end else begin
      for (int g = 0; g < LEVEL; g++) begin
        if (rdy[g]) begin
          a_q[g]   <= a_in[g];
          b_q[g]   <= b_in[g];
          sum_q[g] <= sum_d[g];
          dif_q[g] <= dif_d[g];
          ctl_q[g] <= ctl_in[g];
          val_q[g] <= val_in[g];
          cry_q[g] <= cry_d[g];
          brw_q[g] <= brw_d[g];
        end
      end
    end
  end

  // S >= P exactly when the sum carried out or the difference chain did not borrow.
  logic                ge;
  logic [DAT_BITS-1:0] res;

  assign ge    = cry_in[LEVEL] | ~brw_in[LEVEL];
  assign res   = ge ? dif_in[LEVEL] : sum_in[LEVEL];
  assign o_dat = res[BITS-1:0];
  assign o_ctl = ctl_in[LEVEL];
  assign o_val = val_in[LEVEL];
  assign o_rdy = rdy[0] | i_rst;

  logic unused_bits;
  assign unused_bits = ^{a_in, b_in, res};

endmodule

// File: tb/tb_mod_adder_pipe.sv
// Scoreboard bench for mod_adder_pipe: three instances (LEVEL 1/P=13, LEVEL 2/P=251,
// LEVEL 3/P=251) driven by per-scenario tasks.
module tb_mod_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int lvl[3];

  logic [7:0] a[3], b[3], ctl[3];
  logic       val[3], irdy[3], rst[3], lat_chk[3];

  logic [3:0] od0;
  logic [7:0] od1, od2, oc0, oc1, oc2;
  logic       ov0, ov1, ov2, or0, or1, or2;
  logic [7:0] od[3], oc[3];
  logic       ov[3], ordy[3];

  always_comb begin
    od[0] = {4'b0, od0}; od[1] = od1; od[2] = od2;
    oc[0] = oc0;         oc[1] = oc1; oc[2] = oc2;
    ov[0] = ov0;         ov[1] = ov1; ov[2] = ov2;
    ordy[0] = or0;       ordy[1] = or1; ordy[2] = or2;
  end

  mod_adder_pipe #(.P(13), .CTL_BITS(8), .LEVEL(1)) u_l1 (
    .i_clk(clk), .i_rst(rst[0]), .i_dat_a(a[0][3:0]), .i_dat_b(b[0][3:0]), .i_val(val[0]),
    .i_ctl(ctl[0]), .o_rdy(or0), .o_val(ov0), .o_dat(od0), .o_ctl(oc0), .i_rdy(irdy[0])
  );

  mod_adder_pipe #(.P(251), .CTL_BITS(8), .LEVEL(2)) u_l2 (
    .i_clk(clk), .i_rst(rst[1]), .i_dat_a(a[1]), .i_dat_b(b[1]), .i_val(val[1]),
    .i_ctl(ctl[1]), .o_rdy(or1), .o_val(ov1), .o_dat(od1), .o_ctl(oc1), .i_rdy(irdy[1])
  );

  mod_adder_pipe #(.P(251), .CTL_BITS(8), .LEVEL(3)) u_l3 (
    .i_clk(clk), .i_rst(rst[2]), .i_dat_a(a[2]), .i_dat_b(b[2]), .i_val(val[2]),
    .i_ctl(ctl[2]), .o_rdy(or2), .o_val(ov2), .o_dat(od2), .o_ctl(oc2), .i_rdy(irdy[2])
  );

  typedef struct {
    logic [7:0] dat;
    logic [7:0] ctl;
    int         t;
  } exp_t;

  exp_t sbq[3][$];

  // Output side of the scoreboard: every consumed output must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (ov[k] && irdy[k] && !rst[k]) begin
        checks++;
        if (sbq[k].size() == 0) begin
          errors++;
          $display("FAIL out_unexpected dut%0d: got dat=%0d ctl=%02h, required no output",
                   k, od[k], oc[k]);
        end else begin
          e = sbq[k].pop_front();
          if (od[k] !== e.dat || oc[k] !== e.ctl) begin
            errors++;
            $display("FAIL out_data dut%0d: got dat=%0d ctl=%02h, required dat=%0d ctl=%02h",
                     k, od[k], oc[k], e.dat, e.ctl);
          end
          if (lat_chk[k]) begin
            checks++;
            if (cyc - e.t != lvl[k]) begin
              errors++;
              $display("FAIL latency dut%0d: got %0d cycles, required %0d",
                       k, cyc - e.t, lvl[k]);
            end
          end
        end
      end
    end
  end

  task automatic send(input int k, input logic [7:0] xa, input logic [7:0] xb,
                      input logic [7:0] xc, input logic [7:0] ex);
    int n;
    n = 0;
    a[k] = xa; b[k] = xb; ctl[k] = xc; val[k] = 1'b1;
    @(negedge clk);
    while (ordy[k] !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL accept_timeout dut%0d: got o_rdy=%b for 100 cycles, required 1", k, ordy[k]);
    end else begin
      sbq[k].push_back('{ex, xc, cyc});
    end
    @(posedge clk); #1;
    val[k] = 1'b0;
  endtask

  task automatic wait_drain(input int k);
    int n;
    n = 0;
    while (sbq[k].size() != 0 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (sbq[k].size() != 0) begin
      errors++;
      $display("FAIL drain dut%0d: got %0d outstanding, required 0", k, sbq[k].size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ov[k] !== 1'b0 || od[k] !== 8'd0 || oc[k] !== 8'd0) begin
        errors++;
        $display("FAIL reset_out dut%0d: got val=%b dat=%0d ctl=%02h, required 0/0/00",
                 k, ov[k], od[k], oc[k]);
      end
      checks++;
      if (ordy[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_rdy dut%0d: got %b, required 1", k, ordy[k]);
      end
    end
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    send(1, 8'd100, 8'd100, 8'h11, 8'd200);
    send(1, 8'd200, 8'd100, 8'h22, 8'd49);
    send(1, 8'd250, 8'd250, 8'h33, 8'd249);
    send(1, 8'd125, 8'd126, 8'h44, 8'd0);
    send(1, 8'd0,   8'd0,   8'h55, 8'd0);
    wait_drain(1);
  endtask

  task automatic test_stream();
    logic [7:0] xa, xb;
    int s;
    for (int i = 0; i < 40; i++) begin
      if (i == 0)      begin xa = 8'd250; xb = 8'd250; end
      else if (i == 1) begin xa = 8'd125; xb = 8'd126; end
      else if (i == 2) begin xa = 8'd0;   xb = 8'd0;   end
      else begin
        xa = 8'($urandom_range(250));
        xb = 8'($urandom_range(250));
      end
      s = (int'(xa) + int'(xb)) % 251;
      send(2, xa, xb, 8'(i) ^ 8'hA5, 8'(s));
    end
    wait_drain(2);
  endtask

  task automatic test_backpressure();
    logic [7:0] hd, hc;
    lat_chk[1] = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          int xa, xb;
          xa = (i * 37) % 251;
          xb = (200 + i * 11) % 251;
          send(1, 8'(xa), 8'(xb), 8'h80 + 8'(i), 8'((xa + xb) % 251));
        end
      end
      begin
        repeat (3) @(posedge clk);
        #1 irdy[1] = 1'b0;
        @(negedge clk); #1;
        hd = od[1];
        hc = oc[1];
        checks++;
        if (ov[1] !== 1'b1) begin
          errors++;
          $display("FAIL stall_val: got o_val=%b, required 1", ov[1]);
        end
        repeat (4) begin
          @(negedge clk); #1;
          checks++;
          if (ov[1] !== 1'b1 || od[1] !== hd || oc[1] !== hc) begin
            errors++;
            $display("FAIL stall_stable: got val=%b dat=%0d ctl=%02h, required 1/%0d/%02h",
                     ov[1], od[1], oc[1], hd, hc);
          end
        end
        checks++;
        if (ordy[1] !== 1'b0 || sbq[1].size() != 2) begin
          errors++;
          $display("FAIL stall_full: got o_rdy=%b held=%0d, required o_rdy=0 held=2",
                   ordy[1], sbq[1].size());
        end
        @(posedge clk); #1 irdy[1] = 1'b1;
      end
    join
    wait_drain(1);
    lat_chk[1] = 1'b1;
  endtask

  task automatic test_reset_inflight();
    irdy[1] = 1'b0;
    send(1, 8'd10, 8'd20, 8'h33, 8'd30);
    send(1, 8'd40, 8'd50, 8'h44, 8'd90);
    rst[1] = 1'b1;
    @(negedge clk);
    checks++;
    if (ordy[1] !== 1'b1) begin
      errors++;
      $display("FAIL rst_rdy: got o_rdy=%b during reset, required 1", ordy[1]);
    end
    @(posedge clk); #1;
    checks++;
    if (ov[1] !== 1'b0 || od[1] !== 8'd0 || oc[1] !== 8'd0) begin
      errors++;
      $display("FAIL rst_flush: got val=%b dat=%0d ctl=%02h, required 0/0/00",
               ov[1], od[1], oc[1]);
    end
    rst[1] = 1'b0;
    sbq[1].delete();
    irdy[1] = 1'b1;
    repeat (6) begin
      @(negedge clk); #1;
      checks++;
      if (ov[1] !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale: got o_val=%b after reset, required 0", ov[1]);
      end
    end
    @(posedge clk); #1;
    send(1, 8'd3, 8'd4, 8'h66, 8'd7);
    wait_drain(1);
  endtask

  task automatic test_level1();
    fork
      begin
        send(0, 8'd7,  8'd9,  8'h5A, 8'd3);
        send(0, 8'd12, 8'd12, 8'h01, 8'd11);
        send(0, 8'd6,  8'd7,  8'h02, 8'd0);
        send(0, 8'd0,  8'd12, 8'h03, 8'd12);
        send(0, 8'd5,  8'd4,  8'h04, 8'd9);
      end
      begin
        repeat (6) begin
          @(negedge clk); #1;
          checks++;
          if (ordy[0] !== 1'b1) begin
            errors++;
            $display("FAIL l1_rdy: got o_rdy=%b, required 1", ordy[0]);
          end
        end
      end
    join
    wait_drain(0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500000, required finish");
    $fatal(1);
  end

  initial begin
    lvl[0] = 1; lvl[1] = 2; lvl[2] = 3;
    for (int k = 0; k < 3; k++) begin
      a[k] = '0; b[k] = '0; ctl[k] = '0;
      val[k] = 1'b0; irdy[k] = 1'b1; rst[k] = 1'b1; lat_chk[k] = 1'b1;
    end
    test_reset();
    test_directed();
    test_stream();
    test_backpressure();
    test_reset_inflight();
    test_level1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
